lms_mac: RTL



---
 rtl/lms_mac.sv | 128 ++++++++++++
 1 files changed

// File: rtl/lms_mac.sv
// Pipelined signed multiply-accumulate for the LMS datapath: register, multiply,
// accumulate framed vectors, then round/shift the sum. Define LMS_MAC_SAT_EN to saturate dout.
module lms_mac #(
    parameter int A_W       = 16,
    parameter int B_W       = 16,
    parameter int ACC_W     = 40,
    parameter int OUT_SHIFT = 15,
    parameter int OUT_W     = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ce,
    input  logic                        in_valid,
    input  logic                        in_first,
    input  logic                        in_last,
    input  logic signed [A_W-1:0]       a,
    input  logic signed [B_W-1:0]       b,
    output logic                        prod_valid,
    output logic signed [A_W+B_W-1:0]   prod,
    output logic                        acc_valid,
    output logic signed [ACC_W-1:0]     acc_out,
    output logic signed [OUT_W-1:0]     dout,
    output logic                        ovf
);

    localparam int P_W = A_W + B_W;
    localparam logic signed [ACC_W:0] HALF = (ACC_W + 1)'(1) <<< (OUT_SHIFT - 1);

`ifdef LMS_MAC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic signed [A_W-1:0]   a_reg;
    logic signed [B_W-1:0]   b_reg;
    logic                    valid1_reg, first1_reg, last1_reg;
    logic                    first2_reg, last2_reg;
    logic signed [ACC_W-1:0] acc_reg;
    logic                    last3_reg;

    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W:0]   rnd;
    logic signed [ACC_W:0]   shifted;
    logic                    in_range;
    logic signed [OUT_W-1:0] dout_next;
    logic                    ovf_next;

    // S1: operand and framing registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg      <= '0;
            b_reg      <= '0;
            valid1_reg <= 1'b0;
            first1_reg <= 1'b0;
            last1_reg  <= 1'b0;
        end else if (ce) begin
            a_reg      <= a;
            b_reg      <= b;
            valid1_reg <= in_valid;
            first1_reg <= in_first;
            last1_reg  <= in_last;
        end
    end

    // S2: full-precision product
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod       <= '0;
            prod_valid <= 1'b0;
            first2_reg <= 1'b0;
            last2_reg  <= 1'b0;
        end else if (ce) begin
            prod       <= a_reg * b_reg;
            prod_valid <= valid1_reg;
            first2_reg <= first1_reg;
            last2_reg  <= last1_reg;
        end
    end

    assign prod_ext = ACC_W'(prod);

    // S3: wrapping accumulator; a first term restarts the sum, discarding any open vector
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_reg   <= '0;
            last3_reg <= 1'b0;
        end else if (ce) begin
            if (prod_valid) begin
                acc_reg <= first2_reg ? prod_ext : acc_reg + prod_ext;
            end
            last3_reg <= prod_valid & last2_reg;
        end
    end

    // Round half toward +inf in one extra bit so the bias add cannot wrap
    assign rnd      = {acc_reg[ACC_W-1], acc_reg} + HALF;
    assign shifted  = rnd >>> OUT_SHIFT;
    assign in_range = (&shifted[ACC_W:OUT_W-1]) | ~(|shifted[ACC_W:OUT_W-1]);

    always_comb begin
        dout_next = shifted[OUT_W-1:0];
        ovf_next  = 1'b0;
        if (SAT_EN && !in_range) begin
            ovf_next  = 1'b1;
            dout_next = shifted[ACC_W] ? {1'b1, {(OUT_W-1){1'b0}}}
                                       : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

    // S4: result registers update only on a vector's last term
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_valid <= 1'b0;
            acc_out   <= '0;
            dout      <= '0;
            ovf       <= 1'b0;
        end else if (ce) begin
            acc_valid <= last3_reg;
            if (last3_reg) begin
                acc_out <= acc_reg;
                dout    <= dout_next;
                ovf     <= ovf_next;
            end
        end
    end

endmodule
